// File: rtl/mcu_arbiter.sv
// mcu_arbiter
//   Shares one pool of arithmetic units (integer multiplier, integer divider,
//   FP rounder) between two requesters. A winner is picked round-robin in IDLE,
//   its op is latched, the matching unit gets a one-cycle start pulse, and the
//   owner is told about completion (done) or failure (err: illegal op or the unit
//   stayed busy too long).
//
//   Sequence: IDLE -> ISSUE -> SETTLE -> WAIT -> DONE -> IDLE
//             IDLE -> FAULT -> IDLE             (illegal op 2'b11)
//             WAIT -> FAULT -> IDLE             (timeout)
//
// Ports
//   clk_i          system clock, rising edge
//   reset_ni       asynchronous active-low reset
//   req_i[1:0]     level request per requester (bit0 main ISDU, bit1 secondary)
//   op0_i, op1_i   op per requester: 00 mult, 01 div, 10 fp round, 11 illegal
//   *_busy_i       unit busy flags
//   *_start_o      one-cycle start pulse to each unit
//   grant_o[1:0]   one-hot owner, held from ISSUE/FAULT through DONE/FAULT
//   done_o[1:0]    one-cycle completion pulse to the owner
//   err_o[1:0]     one-cycle error pulse to the owner
//   res_sel_o[1:0] result-mux select (latched op), meaningful only with done_o
//   active_o       high in every state except IDLE
module mcu_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] op0_i,
    input  logic [1:0] op1_i,
    input  logic       mult_busy_i,
    input  logic       div_busy_i,
    input  logic       round_busy_i,
    output logic       mult_start_o,
    output logic       div_start_o,
    output logic       round_start_o,
    output logic [1:0] grant_o,
    output logic [1:0] done_o,
    output logic [1:0] err_o,
    output logic [1:0] res_sel_o,
    output logic       active_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssue  = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StWait   = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;
    localparam logic [2:0] StFault  = 3'd5;

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpDiv   = 2'b01;
    localparam logic [1:0] OpRound = 2'b10;
    localparam logic [1:0] OpIll   = 2'b11;

    // Last busy WAIT cycle that may still be tolerated; counter starts at 0.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic       owner_q, owner_d;  // 0: requester 0, 1: requester 1
    logic [1:0] op_q, op_d;
    logic       ptr_q, ptr_d;      // requester favoured when both request
    logic [7:0] cnt_q, cnt_d;

    logic       win;
    logic [1:0] win_op;
    logic       sel_busy;
    logic [1:0] owner_oh;

    // Round-robin pick: a lone request always wins, a tie goes to ptr_q.
    always_comb begin
        case (req_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ptr_q;
        endcase
        win_op = win ? op1_i : op0_i;
    end

    // Only the unit addressed by the latched op is watched.
    always_comb begin
        case (op_q)
            OpMult:  sel_busy = mult_busy_i;
            OpDiv:   sel_busy = div_busy_i;
            OpRound: sel_busy = round_busy_i;
            default: sel_busy = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (req_i != 2'b00) begin
                    owner_d = win;
                    op_d    = win_op;
                    ptr_d   = ~win;
                    state_d = (win_op == OpIll) ? StFault : StIssue;
                end
            end
            StIssue: begin
                state_d = StSettle;
            end
            StSettle: begin
                cnt_d   = 8'd0;
                state_d = StWait;
            end
            StWait: begin
                if (!sel_busy) begin
                    state_d = StDone;
                end else if (cnt_q == WaitLast) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone, StFault: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            op_q    <= OpMult;
            ptr_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        owner_oh      = owner_q ? 2'b10 : 2'b01;
        active_o      = (state_q != StIdle);
        grant_o       = active_o ? owner_oh : 2'b00;
        mult_start_o  = (state_q == StIssue) && (op_q == OpMult);
        div_start_o   = (state_q == StIssue) && (op_q == OpDiv);
        round_start_o = (state_q == StIssue) && (op_q == OpRound);
        done_o        = (state_q == StDone) ? owner_oh : 2'b00;
        err_o         = (state_q == StFault) ? owner_oh : 2'b00;
        res_sel_o     = (state_q == StDone) ? op_q : 2'b00;
    end

endmodule

// File: tb/tb_mcu_arbiter.sv
// Scoreboard bench for mcu_arbiter (TIMEOUT = 4). Stimulus pushes expected
// start/done/err events and grant runs; the monitor pops them as the DUT
// produces pulses or ends a grant.
module tb_mcu_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] op0 = 2'b00;
    logic [1:0] op1 = 2'b00;
    logic       mult_busy = 1'b0;
    logic       div_busy = 1'b0;
    logic       round_busy = 1'b0;
    logic       mult_start, div_start, round_start;
    logic [1:0] grant, done, err, res_sel;
    logic       active;

    mcu_arbiter #(.TIMEOUT(4)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .req_i         (req),
        .op0_i         (op0),
        .op1_i         (op1),
        .mult_busy_i   (mult_busy),
        .div_busy_i    (div_busy),
        .round_busy_i  (round_busy),
        .mult_start_o  (mult_start),
        .div_start_o   (div_start),
        .round_start_o (round_start),
        .grant_o       (grant),
        .done_o        (done),
        .err_o         (err),
        .res_sel_o     (res_sel),
        .active_o      (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 start ({round,div,mult}), 1 done, 2 err
    typedef struct {
        int kind;
        int val;
        int rs;
        int c;
    } ev_t;
    typedef struct {
        int val;
        int len;
    } gr_t;

    ev_t evq[$];
    gr_t grq[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(input int kind, input int val, input int rs, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.rs   = rs;
        e.c    = c;
        evq.push_back(e);
    endfunction

    function automatic void push_gr(input int val, input int len);
        gr_t g;
        g.val = val;
        g.len = len;
        grq.push_back(g);
    endfunction

    // Monitor
    logic [1:0] run_val = 2'b00;
    int         run_len = 0;

    always @(negedge clk) begin : mon
        logic [2:0] st;
        ev_t        e;
        gr_t        g;
        int         kind;
        int         val;
        st = {round_start, div_start, mult_start};
        if (st != 3'b000 || done != 2'b00 || err != 2'b00) begin
            check("single_output_bit", $countones({st, done, err}), 1);
            if (st != 3'b000) begin
                kind = 0;
                val  = int'(st);
            end else if (done != 2'b00) begin
                kind = 1;
                val  = int'(done);
            end else begin
                kind = 2;
                val  = int'(err);
            end
            if (evq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got kind %0d value %0d, expected none (cycle %0d)",
                         kind, val, cyc);
            end else begin
                e = evq.pop_front();
                check("event_kind", kind, e.kind);
                check("event_value", val, e.val);
                check("event_cycle", cyc, e.c);
                if (kind == 1) check("res_sel", int'(res_sel), e.rs);
                if (kind != 0) check("grant_at_end", int'(grant), val);
            end
        end
        if (run_len > 0 && grant != run_val) begin
            if (grq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_grant: got %0d for %0d cycles, expected none",
                         run_val, run_len);
            end else begin
                g = grq.pop_front();
                check("grant_owner", int'(run_val), g.val);
                check("grant_length", run_len, g.len);
            end
            run_len = 0;
        end
        if (grant != 2'b00) begin
            run_val = grant;
            run_len++;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!active) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: got active=1 after 40 cycles, expected 0");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, int'(grant), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_start"}, int'({round_start, div_start, mult_start}), 0);
        check({tag, "_res_sel"}, int'(res_sel), 0);
        check({tag, "_active"}, int'(active), 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        int l;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Both requesting, held: grants alternate 0,1,0 with one IDLE between.
        c = cyc;
        l = c + 1;
        req = 2'b11;
        op0 = 2'b01;
        op1 = 2'b10;
        push_ev(0, 2, 0, l);      push_ev(1, 1, 1, l + 3);
        push_ev(0, 4, 0, l + 5);  push_ev(1, 2, 2, l + 8);
        push_ev(0, 2, 0, l + 10); push_ev(1, 1, 1, l + 13);
        push_gr(1, 4); push_gr(2, 4); push_gr(1, 4);
        repeat (11) @(negedge clk);
        req = 2'b00;
        wait_idle();

        // Mult busy for 3 WAIT cycles; req and op changed after latch.
        c = cyc;
        l = c + 1;
        req = 2'b01;
        op0 = 2'b00;
        mult_busy = 1'b1;
        push_ev(0, 1, 0, l);
        push_ev(1, 1, 0, l + 6);
        push_gr(1, 7);
        @(negedge clk);
        req = 2'b00;
        op0 = 2'b01;
        repeat (5) @(negedge clk);
        mult_busy = 1'b0;
        wait_idle();

        // Div busy toggling must not disturb a mult op.
        c = cyc;
        l = c + 1;
        req = 2'b01;
        op0 = 2'b00;
        push_ev(0, 1, 0, l);
        push_ev(1, 1, 0, l + 3);
        push_gr(1, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req = 2'b00;
            div_busy = ~div_busy;
        end
        div_busy = 1'b0;
        wait_idle();

        // Illegal op from requester 1: immediate err, no start.
        c = cyc;
        l = c + 1;
        req = 2'b10;
        op1 = 2'b11;
        push_ev(2, 2, 0, l);
        push_gr(2, 1);
        @(negedge clk);
        req = 2'b00;
        wait_idle();

        // Round unit stuck busy: err after 4 busy WAIT cycles.
        c = cyc;
        l = c + 1;
        req = 2'b01;
        op0 = 2'b10;
        round_busy = 1'b1;
        push_ev(0, 4, 0, l);
        push_ev(2, 1, 0, l + 6);
        push_gr(1, 7);
        @(negedge clk);
        req = 2'b00;
        wait_idle();
        round_busy = 1'b0;

        // Reset during WAIT: outputs drop at once, no done/err follows.
        c = cyc;
        l = c + 1;
        req = 2'b01;
        op0 = 2'b00;
        mult_busy = 1'b1;
        push_ev(0, 1, 0, l);
        push_gr(1, 4);
        @(negedge clk);
        req = 2'b00;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        mult_busy = 1'b0;
        @(negedge clk);

        // After release a tie goes to requester 0 again.
        c = cyc;
        l = c + 1;
        reset_n = 1'b1;
        req = 2'b11;
        op0 = 2'b00;
        op1 = 2'b01;
        push_ev(0, 1, 0, l);
        push_ev(1, 1, 0, l + 3);
        push_gr(1, 4);
        @(negedge clk);
        req = 2'b00;
        wait_idle();

        repeat (3) @(negedge clk);
        check("events_left", evq.size(), 0);
        check("grants_left", grq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcu_arbiter.md
MCU_ARBITER -- requirements
Module: mcu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max consecutive busy cycles tolerated in WAIT (legal 1..255).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req  input  2  level request per requester (bit0 = main ISDU, bit1 = secondary).
REQ-005 op0, op1  input  2 each  requested op: 00 int mult, 01 int div, 10 fp round, 11 illegal.
REQ-006 mult_busy, div_busy, round_busy  input  1 each  unit computing, high while busy.
REQ-007 mult_start, div_start, round_start  output  1 each  one-cycle start pulse to unit.
REQ-008 grant  output  2  one-hot owner of the unit pool, held for whole operation.
REQ-009 done  output  2  one-cycle completion pulse to owner.
REQ-010 err  output  2  one-cycle error pulse to owner (illegal op or timeout).
REQ-011 res_sel  output  2  result-mux select (= latched op), valid only while done is high.
REQ-012 active  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, SETTLE, WAIT, DONE, FAULT.
REQ-014 IDLE: if req != 0, latch winner and its op at the edge; go to FAULT if op == 11, else ISSUE; req == 0 stays IDLE.
REQ-015 Arbitration SHALL be round-robin: single request wins; both high -> requester not granted last; pointer after reset favours requester 0.
REQ-016 Arbitration pointer SHALL update only when a grant is latched.
REQ-017 ISSUE: exactly one start output pulses, selected by latched op; next state SETTLE.
REQ-018 SETTLE: busy inputs ignored, no outputs except grant/active; next state WAIT.
REQ-019 WAIT: busy of the selected unit low -> DONE; busy high -> stay, increment 8-bit wait counter.
REQ-020 Wait counter SHALL clear on entry to WAIT; after TIMEOUT consecutive busy-high WAIT cycles the next state SHALL be FAULT.
REQ-021 DONE: done[owner] = 1, res_sel = latched op; next state IDLE.
REQ-022 FAULT: err[owner] = 1, no start pulse issued for illegal op; next state IDLE.
REQ-023 grant SHALL be asserted from ISSUE (or FAULT for illegal op) through DONE/FAULT inclusive, zero in IDLE.
REQ-024 Latency: zero-busy unit -> done pulse 4 cycles after the edge that latched the request (ISSUE, SETTLE, WAIT, DONE).
REQ-025 Busy of non-selected units SHALL be ignored in all states.
REQ-026 op and req changes after latch SHALL NOT affect the operation in progress; deasserted req still completes with done/err.
REQ-027 Requester holding req through the done cycle SHALL be re-arbitrated in the following IDLE cycle (no implicit request drop).
REQ-028 done, err, and start outputs SHALL never be high in the same cycle; at most one bit of done/err set.

Reset
REQ-029 reset_n low SHALL immediately force state IDLE, grant = 0, done = 0, err = 0, all start = 0, res_sel = 0, active = 0, counter = 0, pointer favouring requester 0.
REQ-030 Reset mid-operation SHALL abandon the operation with no done/err pulse; the unit is not notified.
REQ-031 After reset_n rises, the first request SHALL be sampled on the next rising edge.

Verification
REQ-032 req=01, op0=00, mult_busy high 3 WAIT cycles -> one mult_start pulse, grant=01 for 7 cycles, done=01 with res_sel=00 on cycle 7 after latch.
REQ-033 req=11 held, op0=01, op1=10, busy always low -> grants alternate 01,10,01; div_start then round_start; each done 4 cycles after its latch.
REQ-034 req=10, op1=11 -> no start pulse, err=10 one cycle after latch, grant=10 in that cycle, back to IDLE.
REQ-035 TIMEOUT=4, req=01, op0=10, round_busy stuck high -> err=01 after 4 busy WAIT cycles, no done pulse.
REQ-036 reset_n low during WAIT -> all outputs 0 asynchronously; after release, req=11 grants requester 0 first.
REQ-037 div_busy toggling while op=00 in WAIT with mult_busy low -> done on schedule, div_busy ignored.
